// File: rtl/iot_pkg.sv
// Shared types and helpers for the IoT device-activity event encoder.
package iot_pkg;

  // Per-device pending event: nothing, an unreported connect, or an unreported disconnect.
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_ON   = 2'd1,
    PEND_OFF  = 2'd2
  } pend_t;

  localparam int N_DEV_DEFAULT = 8;

  // Device index width; a single device still needs one id bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iot_event_encoder_rr_arbiter.sv
// Combinational round-robin picker. The search starts one past ptr and wraps,
// so the most recently granted device has the lowest priority next time.
module rr_arbiter #(
  parameter int N = 8,
  parameter int W = iot_pkg::id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_id
);

  logic [W-1:0] idx;

  // First requester found walking ptr+1, ptr+2, ... modulo N
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int off = 1; off <= N; off++) begin
      idx = W'((int'(ptr) + off) % N);
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/iot_event_encoder.sv
// Turns device-active level changes into a serial stream of change/on_off pulses,
// one per clock at most, so a downstream counter tracks the number of active devices.
module iot_event_encoder
  import iot_pkg::*;
#(
  parameter int N_DEV = N_DEV_DEFAULT,
  parameter int ID_W  = id_width(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_active,
  input  logic             stall,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic             busy
);

  logic [N_DEV-1:0] dev_prev;
  logic [N_DEV-1:0] rise, fall;
  logic [N_DEV-1:0] req;        // pending != NONE, current state
  logic [N_DEV-1:0] pend_on;    // pending == ON, current state
  logic [N_DEV-1:0] pend_live;  // pending != NONE, next state
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;

  assign rise = dev_active & ~dev_prev;
  assign fall = ~dev_active & dev_prev;

  rr_arbiter #(.N(N_DEV), .W(ID_W)) u_arb (
    .req       (req),
    .en        (~stall),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  for (genvar g = 0; g < N_DEV; g++) begin : g_dev
    pend_t pend_q, pend_d;
    logic  granted;

    assign granted = gnt_valid && (gnt_id == ID_W'(g));

    // Pending-state register for this device
    always_ff @(posedge clk) begin
      if (rst) pend_q <= PEND_NONE;
      else     pend_q <= pend_d;
    end

    // Grant clears first, then a new edge either cancels an opposite pending
    // event or becomes the pending event itself; this keeps grant+edge lossless.
    always_comb begin
      pend_d = pend_q;
      if (granted) pend_d = PEND_NONE;
      if (rise[g])
        pend_d = (pend_d == PEND_OFF) ? PEND_NONE : PEND_ON;
      else if (fall[g])
        pend_d = (pend_d == PEND_ON) ? PEND_NONE : PEND_OFF;
    end

    assign req[g]       = (pend_q != PEND_NONE);
    assign pend_on[g]   = (pend_q == PEND_ON);
    assign pend_live[g] = (pend_d != PEND_NONE);
  end

  // Edge history, arbitration pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      dev_prev <= '0;
      rr_ptr   <= ID_W'(N_DEV - 1);
      change   <= 1'b0;
      on_off   <= 1'b0;
      dev_id   <= '0;
      busy     <= 1'b0;
    end else begin
      dev_prev <= dev_active;
      change   <= gnt_valid;
      busy     <= |pend_live;
      if (gnt_valid) begin
        rr_ptr <= gnt_id;
        dev_id <= gnt_id;
        on_off <= pend_on[gnt_id];
      end
    end
  end

endmodule

// File: tb/tb_iot_event_encoder.sv
// Directed bench: encoder driving a behavioural monitor counter.
module tb_iot_event_encoder;

  localparam int N_DEV = 8;
  localparam int ID_W  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_DEV-1:0] dev_active = '0;
  logic            stall = 1'b0;
  logic            change, on_off, busy;
  logic [ID_W-1:0] dev_id;
  logic [8:0]      cnt;

  int n_vec = 0;
  int n_err = 0;

  iot_event_encoder #(.N_DEV(N_DEV)) dut (
    .clk        (clk),
    .rst        (rst),
    .dev_active (dev_active),
    .stall      (stall),
    .change     (change),
    .on_off     (on_off),
    .dev_id     (dev_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitor: counts active devices from the pulse stream, reset by the same rst
  always @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (change) cnt <= on_off ? cnt + 9'd1 : cnt - 9'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N_DEV-1:0] dv);
    rst = 1'b1;
    dev_active = dv;
    stall = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic chk_pulse(input string tag, input int id, input logic on);
    chk({tag, ".change"}, 32'(change), 32'd1);
    chk({tag, ".id"},     32'(dev_id), 32'(id));
    chk({tag, ".on_off"}, 32'(on_off), 32'(on));
  endtask

  initial begin
    // Reset with devices 0 and 2 already active
    do_reset(8'h05);
    chk("rst.change", 32'(change), 0);
    chk("rst.busy",   32'(busy),   0);
    chk("rst.id",     32'(dev_id), 0);
    chk("rst.on_off", 32'(on_off), 0);
    chk("rst.cnt",    32'(cnt),    0);
    tick();  // rises registered as pending
    chk("r.busy1",   32'(busy),   1);
    chk("r.change1", 32'(change), 0);
    tick(); chk_pulse("r.p0", 0, 1'b1);
    chk("r.busy2", 32'(busy), 1);
    tick(); chk_pulse("r.p2", 2, 1'b1);
    chk("r.busy3", 32'(busy), 0);
    tick();
    chk("r.idle", 32'(change), 0);
    chk("r.cnt",  32'(cnt), 2);

    // All devices on in one cycle: ids 0..7 in order
    do_reset(8'h00);
    dev_active = 8'hFF;
    tick();
    chk("ff.change0", 32'(change), 0);
    for (int i = 0; i < 8; i++) begin
      tick(); chk_pulse($sformatf("ff.p%0d", i), i, 1'b1);
    end
    chk("ff.busy", 32'(busy), 0);
    tick();
    chk("ff.idle", 32'(change), 0);
    chk("ff.cnt",  32'(cnt), 8);

    // Stalled on+off of device 3 cancels
    do_reset(8'h00);
    stall = 1'b1;
    dev_active = 8'h08;
    tick();
    chk("cx.busy1", 32'(busy), 1);
    chk("cx.chg1",  32'(change), 0);
    dev_active = 8'h00;
    tick();
    chk("cx.busy2", 32'(busy), 0);
    chk("cx.chg2",  32'(change), 0);
    stall = 1'b0;
    tick(3);
    chk("cx.chg3", 32'(change), 0);
    chk("cx.cnt",  32'(cnt), 0);

    // Devices 1 and 6 pend under stall, drain after release
    stall = 1'b1;
    dev_active = 8'h42;
    tick(3);
    chk("st.busy", 32'(busy), 1);
    chk("st.chg",  32'(change), 0);
    stall = 1'b0;
    tick(); chk_pulse("st.p1", 1, 1'b1);
    tick(); chk_pulse("st.p6", 6, 1'b1);
    tick();
    chk("st.idle", 32'(change), 0);
    chk("st.busy0", 32'(busy), 0);
    tick();
    chk("st.cnt", 32'(cnt), 2);

    // Device 4 falls in the cycle its ON event is granted
    dev_active = 8'h52;
    tick();
    chk("gf.busy", 32'(busy), 1);
    dev_active = 8'h42;
    tick(); chk_pulse("gf.on", 4, 1'b1);
    chk("gf.busy1", 32'(busy), 1);
    tick(); chk_pulse("gf.off", 4, 1'b0);
    chk("gf.cnt3", 32'(cnt), 3);
    chk("gf.busy2", 32'(busy), 0);
    tick();
    chk("gf.idle", 32'(change), 0);
    chk("gf.cnt", 32'(cnt), 2);

    // Reset mid-drain, then everything re-reported
    dev_active = 8'hFF;
    tick();
    tick(); chk_pulse("md.p5", 5, 1'b1);
    tick(); chk_pulse("md.p7", 7, 1'b1);
    rst = 1'b1;
    tick();
    chk("md.rchg",  32'(change), 0);
    chk("md.rbusy", 32'(busy),   0);
    chk("md.rcnt",  32'(cnt),    0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick(); chk_pulse($sformatf("md.p%0d", i), i, 1'b1);
    end
    tick();
    chk("md.idle", 32'(change), 0);
    chk("md.cnt",  32'(cnt), 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
